// File: rtl/cond_exmem_stage.sv
// Execute-stage condition unit, NZCV flags register and EX/MEM pipeline register.
// Optional feature: define COND_STATS_EN to add ExecCount/SquashCount statistics outputs.
module cond_exmem_stage #(
   parameter int unsigned DW = 32,
   parameter int unsigned RW = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_StallM,
   input  logic          i_FlushM,
   input  logic          i_ValidE,
   input  logic [3:0]    i_CondE,
   input  logic [1:0]    i_FlagWriteE,
   input  logic          i_PCSrcE,
   input  logic          i_RegWriteE,
   input  logic          i_MemWriteE,
   input  logic          i_MemtoRegE,
   input  logic          i_BranchE,
   input  logic [3:0]    i_ALUFlags,
   input  logic [DW-1:0] i_ALUResult,
   input  logic [DW-1:0] i_WriteDataE,
   input  logic [RW-1:0] i_WA3E,
   output logic          o_CondExE,
   output logic          o_BranchTakenE,
   output logic [3:0]    o_Flags,
   output logic          o_PCSrcM,
   output logic          o_RegWriteM,
   output logic          o_MemWriteM,
   output logic          o_MemtoRegM,
   output logic [DW-1:0] o_ALUResultM,
   output logic [DW-1:0] o_WriteDataM,
`ifdef COND_STATS_EN
   output logic [31:0]   o_ExecCount,
   output logic [31:0]   o_SquashCount,
`endif
   output logic [RW-1:0] o_WA3M
);

   logic [3:0]    r_flags;
   logic          r_pcsrc, r_regwrite, r_memwrite, r_memtoreg;
   logic [DW-1:0] r_alu_result, r_write_data;
   logic [RW-1:0] r_wa3;
   logic          w_pass, w_cond_ex, w_advance;
   logic          w_n, w_z, w_c, w_v;

   assign w_n = r_flags[0];
   assign w_z = r_flags[1];
   assign w_c = r_flags[2];
   assign w_v = r_flags[3];

   // Condition is judged against the registered flags, i.e. those of the previous instruction.
   always_comb begin
      w_pass = 1'b0;
      case (i_CondE)
         4'h0: w_pass = w_z;
         4'h1: w_pass = ~w_z;
         4'h2: w_pass = w_c;
         4'h3: w_pass = ~w_c;
         4'h4: w_pass = w_n;
         4'h5: w_pass = ~w_n;
         4'h6: w_pass = w_v;
         4'h7: w_pass = ~w_v;
         4'h8: w_pass = w_c & ~w_z;
         4'h9: w_pass = ~w_c | w_z;
         4'hA: w_pass = (w_n == w_v);
         4'hB: w_pass = (w_n != w_v);
         4'hC: w_pass = ~w_z & (w_n == w_v);
         4'hD: w_pass = w_z | (w_n != w_v);
         4'hE: w_pass = 1'b1;
         default: w_pass = 1'b0;
      endcase
   end

   assign w_cond_ex      = i_ValidE & w_pass;
   assign w_advance      = ~i_StallM & ~i_FlushM;
   assign o_CondExE      = w_cond_ex;
   assign o_BranchTakenE = i_BranchE & w_cond_ex;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pcsrc      <= 1'b0;
         r_regwrite   <= 1'b0;
         r_memwrite   <= 1'b0;
         r_memtoreg   <= 1'b0;
         r_alu_result <= '0;
         r_write_data <= '0;
         r_wa3        <= '0;
      end else if (i_FlushM) begin
         r_pcsrc      <= 1'b0;
         r_regwrite   <= 1'b0;
         r_memwrite   <= 1'b0;
         r_memtoreg   <= 1'b0;
      end else if (!i_StallM) begin
         r_pcsrc      <= i_PCSrcE & w_cond_ex;
         r_regwrite   <= i_RegWriteE & w_cond_ex;
         r_memwrite   <= i_MemWriteE & w_cond_ex;
         r_memtoreg   <= i_MemtoRegE;
         r_alu_result <= i_ALUResult;
         r_write_data <= i_WriteDataE;
         r_wa3        <= i_WA3E;
      end
   end

   // Each half is only written when enabled, so X on unused ALUFlags bits never propagates.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_flags <= 4'b0000;
      end else if (w_advance && w_cond_ex) begin
         if (i_FlagWriteE[1]) r_flags[1:0] <= i_ALUFlags[1:0];
         if (i_FlagWriteE[0]) r_flags[3:2] <= i_ALUFlags[3:2];
      end
   end

`ifdef COND_STATS_EN
   logic [31:0] r_exec_count, r_squash_count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_exec_count   <= '0;
         r_squash_count <= '0;
      end else if (w_advance && i_ValidE) begin
         if (w_cond_ex) r_exec_count   <= r_exec_count + 32'd1;
         else           r_squash_count <= r_squash_count + 32'd1;
      end
   end

   assign o_ExecCount   = r_exec_count;
   assign o_SquashCount = r_squash_count;
`endif

   assign o_Flags      = r_flags;
   assign o_PCSrcM     = r_pcsrc;
   assign o_RegWriteM  = r_regwrite;
   assign o_MemWriteM  = r_memwrite;
   assign o_MemtoRegM  = r_memtoreg;
   assign o_ALUResultM = r_alu_result;
   assign o_WriteDataM = r_write_data;
   assign o_WA3M       = r_wa3;

endmodule
